cache_req_arbiter: RTL



---
 rtl/cache_req_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cache_req_arbiter.sv
// Cache request arbiter: merges NUM_CH cache request channels onto a single
// memory port with one outstanding transaction. Supports fixed-priority or
// round-robin selection, and a per-channel flush that suppresses the response
// of a squashed request without aborting the memory transaction.
module cache_req_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1,
  localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req_valid_i,
  input  logic [NUM_CH-1:0]        ch_wen_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  input  logic [NUM_CH*2-1:0]      ch_wlen_i,
  input  logic [NUM_CH-1:0]        ch_flush_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic [NUM_CH-1:0]        ch_data_valid_o,
  output logic [DATA_W-1:0]        ch_data_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_ready_i,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic                     mem_wen_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic [1:0]               mem_wlen_o,
  input  logic                     mem_data_valid_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  output logic                     busy_o,
  output logic [GW-1:0]            grant_id_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [NUM_CH-1:0] elig;
  logic              any_elig;
  logic              grant;
  logic [GW-1:0]     winner;
  logic [GW-1:0]     last_grant;
  logic              drop;
  logic              owner_flush;
  logic              resp_fire;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wen;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_wlen;

  // Lowest eligible index wins.
  function automatic logic [GW-1:0] pick_fixed(input logic [NUM_CH-1:0] req);
    logic [GW-1:0] w;
    w = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) w = GW'(i);
    end
    return w;
  endfunction

  // Search starts one past the previous winner and wraps around.
  function automatic logic [GW-1:0] pick_rr(input logic [NUM_CH-1:0] req,
                                            input logic [GW-1:0]     last);
    logic [GW-1:0] w;
    logic [GW-1:0] ix;
    logic          found;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      ix = GW'((int'(last) + k) % NUM_CH);
      if (!found && req[ix]) begin
        w     = ix;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // A flushing channel is never granted, even if it also holds valid.
  always_comb begin
    elig     = ch_req_valid_i & ~ch_flush_i;
    any_elig = |elig;
    winner   = (RR_EN != 0) ? pick_rr(elig, last_grant) : pick_fixed(elig);
    grant    = (state == ST_IDLE) && any_elig;
  end

  // Payload of the selected channel, captured on grant.
  always_comb begin
    sel_addr  = ch_addr_i[winner*ADDR_W +: ADDR_W];
    sel_wen   = ch_wen_i[winner];
    sel_wdata = ch_wdata_i[winner*DATA_W +: DATA_W];
    sel_wlen  = ch_wlen_i[winner*2 +: 2];
  end

  // Flush of the owner suppresses the response, including a same-cycle flush.
  always_comb begin
    owner_flush = ch_flush_i[grant_id_o];
    resp_fire   = (state == ST_WAIT) && mem_data_valid_i && !drop && !owner_flush;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic: grant, wait for memory accept, wait for data/ack.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_elig)         state_next = ST_REQ;
      ST_REQ:  if (mem_ready_i)      state_next = ST_WAIT;
      ST_WAIT: if (mem_data_valid_i) state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  // Output decode: accept pulse in IDLE, request in REQ, response in WAIT.
  always_comb begin
    ch_ready_o      = '0;
    ch_data_valid_o = '0;
    ch_data_o       = '0;
    mem_req_valid_o = (state == ST_REQ);
    busy_o          = (state != ST_IDLE);
    if (grant && rst) ch_ready_o[winner] = 1'b1;
    if (resp_fire) begin
      ch_data_valid_o[grant_id_o] = 1'b1;
      ch_data_o                   = mem_data_i;
    end
  end

  // Transaction registers: payload and owner latched on grant, held until next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_o  <= '0;
      mem_wen_o   <= 1'b0;
      mem_wdata_o <= '0;
      mem_wlen_o  <= 2'b00;
      grant_id_o  <= '0;
      last_grant  <= GW'(NUM_CH - 1);
    end else if (grant) begin
      mem_addr_o  <= sel_addr;
      mem_wen_o   <= sel_wen;
      mem_wdata_o <= sel_wdata;
      mem_wlen_o  <= sel_wlen;
      grant_id_o  <= winner;
      last_grant  <= winner;
    end
  end

  // Drop flag: cleared on grant, set by an owner flush while the transaction is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 drop <= 1'b0;
    else if (grant)                           drop <= 1'b0;
    else if ((state != ST_IDLE) && owner_flush) drop <= 1'b1;
  end

endmodule
